// File: rtl/bsg_channel_widen_buffered_if.sv
// Handshake bundle for the narrow-to-wide packer.
// Narrow beats flow in on data_i/v_i/last_i/ready_o; packed words flow out on data_o/partial_o/v_o/ready_i.
interface bsg_channel_widen_buffered_if #(
    parameter int width_in_p  = 16,
    parameter int width_out_p = 32
);
    logic [width_in_p-1:0]  data_i;
    logic                   v_i;
    logic                   last_i;
    logic                   ready_o;
    logic [width_out_p-1:0] data_o;
    logic                   partial_o;
    logic                   v_o;
    logic                   ready_i;

    // Master: produces narrow beats and consumes wide words.
    modport master (
        output data_i, v_i, last_i, ready_i,
        input  ready_o, data_o, partial_o, v_o
    );

    // Slave: the packer itself.
    modport slave (
        input  data_i, v_i, last_i, ready_i,
        output ready_o, data_o, partial_o, v_o
    );
endinterface

// File: rtl/bsg_channel_widen_buffered.sv
// Packs ratio_lp narrow beats into one wide word, with an early close on last_i,
// and holds completed words in a 2-entry buffer so packing continues under backpressure.
module bsg_channel_widen_buffered #(
    parameter int width_in_p   = 16,
    parameter int width_out_p  = 32,
    parameter bit lsb_to_msb_p = 1'b1
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    bsg_channel_widen_buffered_if.slave    ch
);
    localparam int ratio_lp = width_out_p / width_in_p;
    localparam int cnt_w_lp = (ratio_lp > 2) ? $clog2(ratio_lp) : 1;
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(ratio_lp - 1);

    typedef struct packed {
        logic [width_out_p-1:0] word;
        logic                   partial;
    } entry_t;

    logic [cnt_w_lp-1:0]    cnt_q, cnt_d;
    logic [width_out_p-1:0] asm_q, asm_d;
    entry_t                 buf_q [2];
    entry_t                 buf_d [2];
    logic [1:0]             out_cnt_q, out_cnt_d;
    logic                   ready_q, ready_d;

    logic                   accept;
    logic                   complete;
    logic                   pop;
    logic                   final_slot;
    logic [cnt_w_lp-1:0]    slot;
    logic [1:0]             after_pop;
    logic [width_out_p-1:0] word_w;

    // Current word with the incoming beat merged into its slot.
    always_comb begin
        final_slot = (cnt_q == cnt_max_lp);
        slot       = lsb_to_msb_p ? cnt_q : (cnt_max_lp - cnt_q);
        accept     = ch.v_i & ready_q;
        complete   = accept & (final_slot | ch.last_i);
        pop        = (out_cnt_q != 2'd0) & ch.ready_i;
        word_w     = asm_q;
        for (int i = 0; i < ratio_lp; i++) begin
            if (slot == cnt_w_lp'(i)) begin
                word_w[i*width_in_p +: width_in_p] = ch.data_i;
            end
        end
    end

    // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
    always_comb begin
        cnt_d = cnt_q;
        asm_d = asm_q;
        if (accept) begin
            if (complete) begin
                cnt_d = '0;
                asm_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
                asm_d = word_w;
            end
        end

        // Pop shifts the second entry forward; a push lands behind whatever survives the pop.
        buf_d     = buf_q;
        after_pop = out_cnt_q - {1'b0, pop};
        if (pop) begin
            buf_d[0] = buf_q[1];
            buf_d[1] = '0;
        end
        if (complete) begin
            buf_d[after_pop[0]] = '{word: word_w, partial: ch.last_i & ~final_slot};
        end
        out_cnt_d = after_pop + {1'b0, complete};
        ready_d   = (out_cnt_d != 2'd2);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    // NOTE: the two buffer entries are reset as well, since data_o must read 0 while in reset.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            cnt_q     <= '0;
            asm_q     <= '0;
            buf_q[0]  <= '0;
            buf_q[1]  <= '0;
            out_cnt_q <= 2'd0;
            ready_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            asm_q     <= asm_d;
            buf_q     <= buf_d;
            out_cnt_q <= out_cnt_d;
            ready_q   <= ready_d;
        end
    end

    assign ch.ready_o   = ready_q;
    assign ch.v_o       = (out_cnt_q != 2'd0);
    assign ch.data_o    = buf_q[0].word;
    assign ch.partial_o = buf_q[0].partial;

    if (((width_out_p % width_in_p) != 0) || (ratio_lp < 2)) begin : g_param_check
        $error("width_out_p must be an integer multiple >= 2 of width_in_p");
    end

    a_no_overflow : assert property (@(posedge clk_i) disable iff (reset_i)
        !(complete && (out_cnt_q == 2'd2)))
        else $error("push into a full output buffer");
endmodule

// File: tb/tb_bsg_channel_widen_buffered.sv
// Bench for bsg_channel_widen_buffered: vector table, directed corner cases and a
// randomized run against a queue-based model of the packing rules.
module tb_bsg_channel_widen_buffered;
    localparam int WI = 16;
    localparam int WO = 32;
    localparam int RATIO = WO / WI;

    logic clk = 1'b0;
    logic reset_i = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   words_out = 0;

    always #5 clk = ~clk;

    bsg_channel_widen_buffered_if #(.width_in_p(WI), .width_out_p(WO)) ch_a ();
    bsg_channel_widen_buffered_if #(.width_in_p(WI), .width_out_p(WO)) ch_b ();

    bsg_channel_widen_buffered #(.width_in_p(WI), .width_out_p(WO), .lsb_to_msb_p(1'b1)) dut_a (
        .clk_i(clk), .reset_i(reset_i), .ch(ch_a)
    );
    bsg_channel_widen_buffered #(.width_in_p(WI), .width_out_p(WO), .lsb_to_msb_p(1'b0)) dut_b (
        .clk_i(clk), .reset_i(reset_i), .ch(ch_b)
    );

    typedef struct packed {
        logic [WO-1:0] word;
        logic          partial;
    } exp_t;

    typedef struct {
        logic          v;
        logic          last;
        logic [WI-1:0] d;
        logic          rdy;
        logic          exp_v;
        logic [WO-1:0] exp_d;
        logic          exp_p;
        logic          exp_rdy;
    } vec_t;

    exp_t          exp_q[$];
    logic [WI-1:0] beats[$];
    vec_t          vecs[17];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One cycle against the model: compare outputs, drive inputs, advance the model, clock.
    task automatic model_cycle(input logic v, input logic last, input logic [WI-1:0] d, input logic rdy);
        logic    acc;
        logic    pp;
        exp_t    e;
        check("model_v_o", ch_a.v_o, exp_q.size() != 0);
        check("model_ready_o", ch_a.ready_o, exp_q.size() != 2);
        if (exp_q.size() != 0) begin
            check("model_data_o", ch_a.data_o, exp_q[0].word);
            check("model_partial_o", ch_a.partial_o, exp_q[0].partial);
        end
        ch_a.v_i     = v;
        ch_a.last_i  = last;
        ch_a.data_i  = d;
        ch_a.ready_i = rdy;
        acc = v && (exp_q.size() != 2);
        pp  = rdy && (exp_q.size() != 0);
        if (pp) begin
            void'(exp_q.pop_front());
            words_out++;
        end
        if (acc) begin
            beats.push_back(d);
            if (last || beats.size() == RATIO) begin
                e.word = '0;
                for (int k = 0; k < beats.size(); k++) e.word[k*WI +: WI] = beats[k];
                e.partial = last && (beats.size() != RATIO);
                exp_q.push_back(e);
                beats.delete();
            end
        end
        tick();
    endtask

    initial begin
        int w0;
        ch_a.v_i = 0; ch_a.last_i = 0; ch_a.data_i = '0; ch_a.ready_i = 1;
        ch_b.v_i = 0; ch_b.last_i = 0; ch_b.data_i = '0; ch_b.ready_i = 1;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_v_o", ch_a.v_o, 0);
        check("rst_ready_o", ch_a.ready_o, 0);
        check("rst_data_o", ch_a.data_o, 0);
        check("rst_partial_o", ch_a.partial_o, 0);
        #3 reset_i = 0;
        #1 check("rst_release_ready_low", ch_a.ready_o, 0);
        @(posedge clk);
        #1 check("rst_release_ready_high", ch_a.ready_o, 1);

        // Basic pack, early close, and backpressure fill/drain on the LSB-first instance.
        vecs[0]  = '{1, 0, 16'h1111, 1, 0, 32'h0,         0, 1};
        vecs[1]  = '{1, 0, 16'h2222, 1, 1, 32'h2222_1111, 0, 1};
        vecs[2]  = '{0, 0, 16'h0000, 1, 0, 32'h0,         0, 1};
        vecs[3]  = '{1, 1, 16'h1234, 1, 1, 32'h0000_1234, 1, 1};
        vecs[4]  = '{1, 0, 16'h5555, 1, 0, 32'h0,         0, 1};
        vecs[5]  = '{1, 0, 16'h6666, 1, 1, 32'h6666_5555, 0, 1};
        vecs[6]  = '{0, 0, 16'h0000, 1, 0, 32'h0,         0, 1};
        vecs[7]  = '{1, 0, 16'h0001, 0, 0, 32'h0,         0, 1};
        vecs[8]  = '{1, 0, 16'h0002, 0, 1, 32'h0002_0001, 0, 1};
        vecs[9]  = '{1, 0, 16'h0003, 0, 1, 32'h0002_0001, 0, 1};
        vecs[10] = '{1, 0, 16'h0004, 0, 1, 32'h0002_0001, 0, 0};
        vecs[11] = '{1, 0, 16'h0005, 0, 1, 32'h0002_0001, 0, 0};
        vecs[12] = '{1, 0, 16'h0005, 0, 1, 32'h0002_0001, 0, 0};
        vecs[13] = '{1, 0, 16'h0005, 1, 1, 32'h0004_0003, 0, 1};
        vecs[14] = '{1, 0, 16'h0005, 1, 0, 32'h0,         0, 1};
        vecs[15] = '{1, 0, 16'h0006, 1, 1, 32'h0006_0005, 0, 1};
        vecs[16] = '{0, 0, 16'h0000, 1, 0, 32'h0,         0, 1};
        for (int i = 0; i < 17; i++) begin
            ch_a.v_i     = vecs[i].v;
            ch_a.last_i  = vecs[i].last;
            ch_a.data_i  = vecs[i].d;
            ch_a.ready_i = vecs[i].rdy;
            tick();
            check($sformatf("vec%0d_v_o", i), ch_a.v_o, vecs[i].exp_v);
            check($sformatf("vec%0d_ready_o", i), ch_a.ready_o, vecs[i].exp_rdy);
            if (vecs[i].exp_v) begin
                check($sformatf("vec%0d_data_o", i), ch_a.data_o, vecs[i].exp_d);
                check($sformatf("vec%0d_partial_o", i), ch_a.partial_o, vecs[i].exp_p);
            end
        end
        ch_a.v_i = 0;

        // MSB-first ordering.
        ch_b.v_i = 1; ch_b.data_i = 16'hAAAA;
        tick();
        ch_b.data_i = 16'hBBBB;
        tick();
        ch_b.v_i = 0;
        check("msb_first_v_o", ch_b.v_o, 1);
        check("msb_first_data_o", ch_b.data_o, 32'hAAAA_BBBB);
        check("msb_first_partial_o", ch_b.partial_o, 0);
        tick();
        check("msb_first_popped", ch_b.v_o, 0);

        // Streaming: 64 beats with ready_i held high.
        w0 = words_out;
        for (int i = 0; i < 64; i++) model_cycle(1'b1, 1'b0, WI'($urandom), 1'b1);
        model_cycle(1'b0, 1'b0, '0, 1'b1);
        check("stream_word_count", words_out - w0, 32);

        // Randomized traffic with early closes and backpressure.
        for (int i = 0; i < 400; i++) begin
            model_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
                        WI'($urandom), $urandom_range(0, 2) != 0);
        end
        // Close any open word and drain.
        while (beats.size() != 0) model_cycle(1'b1, 1'b1, WI'($urandom), 1'b1);
        repeat (4) model_cycle(1'b0, 1'b0, '0, 1'b1);

        // Asynchronous reset with a pending word and a half-built word.
        model_cycle(1'b1, 1'b0, 16'h00AA, 1'b0);
        model_cycle(1'b1, 1'b0, 16'h00BB, 1'b0);
        model_cycle(1'b1, 1'b0, 16'h7777, 1'b0);
        ch_a.v_i = 0;
        check("pre_reset_v_o", ch_a.v_o, 1);
        #3 reset_i = 1;
        #1;
        check("async_reset_v_o", ch_a.v_o, 0);
        check("async_reset_ready_o", ch_a.ready_o, 0);
        exp_q.delete();
        beats.delete();
        tick();
        reset_i = 0;
        tick();
        model_cycle(1'b1, 1'b0, 16'h0001, 1'b1);
        model_cycle(1'b1, 1'b0, 16'h0002, 1'b1);
        check("post_reset_data_o", ch_a.data_o, 32'h0002_0001);
        model_cycle(1'b0, 1'b0, '0, 1'b1);
        model_cycle(1'b0, 1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
